// File: rtl/pwm_pkg.sv
// Shared types and constants for the switching-frequency selector path:
// debounce FSM state encoding, selector width/limits and a selector step helper.
package pwm_pkg;

    typedef enum logic [1:0] {
        DB_IDLE         = 2'b00,
        DB_WAIT_PRESS   = 2'b01,
        DB_PRESSED      = 2'b10,
        DB_WAIT_RELEASE = 2'b11
    } db_state_t;

    localparam int              SEL_W   = 3;
    localparam logic [SEL_W-1:0] SEL_MIN = 3'b000;
    localparam logic [SEL_W-1:0] SEL_MAX = 3'b111;

    // One selector step; dec=1 moves toward SEL_MIN (higher frequency).
    // With wrap_en=0 the step saturates at the limits.
    function automatic logic [SEL_W-1:0] sel_step(
        input logic [SEL_W-1:0] sel,
        input logic             dec,
        input logic             wrap_en
    );
        logic [SEL_W-1:0] result;
        result = sel;
        if (dec) begin
            if (wrap_en || (sel != SEL_MIN)) begin
                result = sel - SEL_W'(1);
            end
        end else begin
            if (wrap_en || (sel != SEL_MAX)) begin
                result = sel + SEL_W'(1);
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// One push-button front end: two-flop synchronizer, press/release debounce FSM
// with a stability counter, and a single-cycle press_pulse per accepted press.
module btn_debounce
    import pwm_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn,
    output logic press_pulse
);

    localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [1:0]    sync_reg;
    logic          level;
    db_state_t     state_reg, state_next;
    logic [CW-1:0] cnt_reg, cnt_next;
    logic          pulse_reg, pulse_next;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_reg <= 2'b00;
        end else begin
            sync_reg <= {sync_reg[0], btn};
        end
    end

    assign level = sync_reg[1];

    // cnt only advances while the level matches the state being qualified,
    // and leaves the wait state at CNT_LAST, so it can never wrap.
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        pulse_next = 1'b0;
        case (state_reg)
            DB_IDLE: begin
                if (level) begin
                    state_next = DB_WAIT_PRESS;
                    cnt_next   = '0;
                end
            end
            DB_WAIT_PRESS: begin
                if (!level) begin
                    state_next = DB_IDLE;
                end else if (cnt_reg == CNT_LAST) begin
                    state_next = DB_PRESSED;
                    pulse_next = 1'b1;
                end else begin
                    cnt_next = cnt_reg + CW'(1);
                end
            end
            DB_PRESSED: begin
                if (!level) begin
                    state_next = DB_WAIT_RELEASE;
                    cnt_next   = '0;
                end
            end
            DB_WAIT_RELEASE: begin
                if (level) begin
                    state_next = DB_PRESSED;
                end else if (cnt_reg == CNT_LAST) begin
                    state_next = DB_IDLE;
                end else begin
                    cnt_next = cnt_reg + CW'(1);
                end
            end
            default: begin
                state_next = DB_IDLE;
                cnt_next   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= DB_IDLE;
            cnt_reg   <= '0;
            pulse_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            pulse_reg <= pulse_next;
        end
    end

    assign press_pulse = pulse_reg;

endmodule

// File: rtl/freq_select_counter.sv
// Push-button driven 3-bit frequency selector (000 = fastest, 111 = slowest).
// Define FREQ_SEL_WRAP_EN to make the selector wrap at its limits instead of saturating.
module freq_select_counter
    import pwm_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             btn_up,
    input  logic             btn_down,
    output logic [SEL_W-1:0] selector,
    output logic             sel_changed,
    output logic             at_max,
    output logic             at_min
);

`ifdef FREQ_SEL_WRAP_EN
    localparam logic WRAP_EN = 1'b1;
`else
    localparam logic WRAP_EN = 1'b0;
`endif

    logic [1:0] btn_raw;
    logic [1:0] press_vec;

    // Index 0 is the up (decrement) button, index 1 the down (increment) button.
    assign btn_raw = {btn_down, btn_up};

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_btn
            btn_debounce #(
                .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
            ) u_debounce (
                .clk        (clk),
                .rst_n      (rst_n),
                .btn        (btn_raw[gi]),
                .press_pulse(press_vec[gi])
            );
        end
    endgenerate

    logic [SEL_W-1:0] sel_reg, sel_next;
    logic             changed_reg, changed_next;
    logic             at_max_reg, at_min_reg;

    // Simultaneous requests cancel; saturated steps leave sel_next unchanged,
    // so changed_next naturally stays low for them.
    always_comb begin
        sel_next = sel_reg;
        case (press_vec)
            2'b01:   sel_next = sel_step(sel_reg, 1'b1, WRAP_EN);
            2'b10:   sel_next = sel_step(sel_reg, 1'b0, WRAP_EN);
            default: sel_next = sel_reg;
        endcase
        changed_next = (sel_next != sel_reg);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sel_reg     <= SEL_MIN;
            changed_reg <= 1'b0;
            at_max_reg  <= 1'b0;
            at_min_reg  <= 1'b1;
        end else begin
            sel_reg     <= sel_next;
            changed_reg <= changed_next;
            at_max_reg  <= (sel_next == SEL_MAX);
            at_min_reg  <= (sel_next == SEL_MIN);
        end
    end

    assign selector    = sel_reg;
    assign sel_changed = changed_reg;
    assign at_max      = at_max_reg;
    assign at_min      = at_min_reg;

endmodule

// File: tb/tb_freq_select_counter.sv
// Directed self-checking bench for freq_select_counter with DEBOUNCE_CYCLES = 4.
module tb_freq_select_counter;

    localparam int DC = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       btn_up = 1'b0;
    logic       btn_down = 1'b0;
    logic [2:0] selector;
    logic       sel_changed;
    logic       at_max;
    logic       at_min;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    freq_select_counter #(
        .DEBOUNCE_CYCLES(DC)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .btn_up     (btn_up),
        .btn_down   (btn_down),
        .selector   (selector),
        .sel_changed(sel_changed),
        .at_max     (at_max),
        .at_min     (at_min)
    );

    // Advance n rising edges; outputs are then sampled 1 ns after the edge.
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic count_pulses(input int n, output int pulses);
        pulses = 0;
        repeat (n) begin
            tick(1);
            if (sel_changed) pulses++;
        end
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        tick(3);
        rst_n = 1'b1;
        tick(1);
    endtask

    // Clean press held 15 cycles, then a release long enough to fully debounce.
    task automatic press(input logic up, input logic down, output int p_hold, output int p_rel);
        btn_up   = up;
        btn_down = down;
        count_pulses(15, p_hold);
        btn_up   = 1'b0;
        btn_down = 1'b0;
        count_pulses(10, p_rel);
    endtask

    function automatic logic [2:0] model_next(input logic [2:0] s, input logic up, input logic down);
        logic [2:0] r;
        r = s;
        if (up && !down) begin
`ifdef FREQ_SEL_WRAP_EN
            r = s - 3'd1;
`else
            r = (s == 3'd0) ? s : s - 3'd1;
`endif
        end else if (down && !up) begin
`ifdef FREQ_SEL_WRAP_EN
            r = s + 3'd1;
`else
            r = (s == 3'd7) ? s : s + 3'd1;
`endif
        end
        return r;
    endfunction

    task automatic test_reset();
        rst_n = 1'b0;
        tick(3);
        rst_n = 1'b1;
        tick(1);
        checks++; if (selector !== 3'b000) begin errors++; $display("FAIL reset_selector got %b expected 000", selector); end
        checks++; if (at_min !== 1'b1) begin errors++; $display("FAIL reset_at_min got %b expected 1", at_min); end
        checks++; if (at_max !== 1'b0) begin errors++; $display("FAIL reset_at_max got %b expected 0", at_max); end
        checks++; if (sel_changed !== 1'b0) begin errors++; $display("FAIL reset_sel_changed got %b expected 0", sel_changed); end
        $display("reset: selector=%b at_min=%b at_max=%b", selector, at_min, at_max);
    endtask

    task automatic test_single_press();
        int p;
        btn_down = 1'b1;
        tick(7);
        checks++; if (selector !== 3'b000) begin errors++; $display("FAIL single_early got %b expected 000", selector); end
        tick(1);
        checks++; if (selector !== 3'b001) begin errors++; $display("FAIL single_latency got %b expected 001", selector); end
        checks++; if (sel_changed !== 1'b1) begin errors++; $display("FAIL single_pulse got %b expected 1", sel_changed); end
        count_pulses(12, p);
        checks++; if (p !== 0) begin errors++; $display("FAIL single_hold_pulses got %0d expected 0", p); end
        checks++; if (selector !== 3'b001) begin errors++; $display("FAIL single_hold_sel got %b expected 001", selector); end
        btn_down = 1'b0;
        count_pulses(12, p);
        checks++; if (p !== 0) begin errors++; $display("FAIL single_release_pulses got %0d expected 0", p); end
        $display("single press: selector=%b", selector);
    endtask

    task automatic test_bounce();
        int a, b, c, d, e, p;
        btn_down = 1'b1; count_pulses(2, a);
        btn_down = 1'b0; count_pulses(2, b);
        btn_down = 1'b1; count_pulses(2, c);
        btn_down = 1'b0; count_pulses(2, d);
        btn_down = 1'b1; count_pulses(7, e);
        checks++; if (a + b + c + d + e !== 0) begin errors++; $display("FAIL bounce_early_pulses got %0d expected 0", a + b + c + d + e); end
        checks++; if (selector !== 3'b001) begin errors++; $display("FAIL bounce_early_sel got %b expected 001", selector); end
        tick(1);
        checks++; if (selector !== 3'b010) begin errors++; $display("FAIL bounce_latency got %b expected 010", selector); end
        checks++; if (sel_changed !== 1'b1) begin errors++; $display("FAIL bounce_pulse got %b expected 1", sel_changed); end
        count_pulses(6, p);
        // Release bounce: back to PRESSED, must not request again.
        btn_down = 1'b0; count_pulses(2, a);
        btn_down = 1'b1; count_pulses(3, b);
        btn_down = 1'b0; count_pulses(12, c);
        checks++; if (p + a + b + c !== 0) begin errors++; $display("FAIL bounce_release_pulses got %0d expected 0", p + a + b + c); end
        checks++; if (selector !== 3'b010) begin errors++; $display("FAIL bounce_final_sel got %b expected 010", selector); end
        $display("bounce: selector=%b", selector);
    endtask

    task automatic test_simultaneous();
        int ph, pr;
        apply_reset();
        repeat (3) press(1'b0, 1'b1, ph, pr);
        checks++; if (selector !== 3'b011) begin errors++; $display("FAIL simul_setup got %b expected 011", selector); end
        press(1'b1, 1'b1, ph, pr);
        checks++; if (ph + pr !== 0) begin errors++; $display("FAIL simul_pulses got %0d expected 0", ph + pr); end
        checks++; if (selector !== 3'b011) begin errors++; $display("FAIL simul_sel got %b expected 011", selector); end
        $display("simultaneous: selector=%b", selector);
    endtask

    task automatic test_saturation();
        int ph, pr;
        logic [2:0] exp_sel, prev;
        apply_reset();
        exp_sel = 3'b000;
        for (int k = 1; k <= 9; k++) begin
            prev = exp_sel;
            exp_sel = model_next(exp_sel, 1'b0, 1'b1);
            press(1'b0, 1'b1, ph, pr);
            checks++; if (selector !== exp_sel) begin errors++; $display("FAIL down%0d_sel got %b expected %b", k, selector, exp_sel); end
            checks++; if (ph !== ((exp_sel != prev) ? 1 : 0) || pr !== 0) begin errors++; $display("FAIL down%0d_pulses got %0d/%0d expected %0d/0", k, ph, pr, (exp_sel != prev) ? 1 : 0); end
            checks++; if (at_max !== (exp_sel == 3'b111) || at_min !== (exp_sel == 3'b000)) begin errors++; $display("FAIL down%0d_flags got max=%b min=%b for %b", k, at_max, at_min, exp_sel); end
            $display("down press %0d: selector=%b pulses=%0d", k, selector, ph);
        end
        // Up requests: normal decrement or wrap, then the lower limit from reset.
        prev = exp_sel;
        exp_sel = model_next(exp_sel, 1'b1, 1'b0);
        press(1'b1, 1'b0, ph, pr);
        checks++; if (selector !== exp_sel || ph !== ((exp_sel != prev) ? 1 : 0)) begin errors++; $display("FAIL up_step got %b/%0d expected %b", selector, ph, exp_sel); end
        apply_reset();
        exp_sel = model_next(3'b000, 1'b1, 1'b0);
        press(1'b1, 1'b0, ph, pr);
        checks++; if (selector !== exp_sel || ph !== ((exp_sel != 3'b000) ? 1 : 0)) begin errors++; $display("FAIL up_at_min got %b/%0d expected %b", selector, ph, exp_sel); end
        checks++; if (at_max !== (exp_sel == 3'b111) || at_min !== (exp_sel == 3'b000)) begin errors++; $display("FAIL up_at_min_flags got max=%b min=%b for %b", at_max, at_min, exp_sel); end
        $display("up at min: selector=%b", selector);
    endtask

    task automatic test_reset_mid_press();
        int p;
        apply_reset();
        btn_down = 1'b1;
        tick(3);
        rst_n = 1'b0;
        #1;
        checks++; if (selector !== 3'b000 || at_min !== 1'b1) begin errors++; $display("FAIL midrst_async got sel=%b min=%b expected 000/1", selector, at_min); end
        tick(2);
        rst_n = 1'b1;
        count_pulses(7, p);
        checks++; if (p !== 0 || selector !== 3'b000) begin errors++; $display("FAIL midrst_early got sel=%b pulses=%0d expected 000/0", selector, p); end
        tick(1);
        checks++; if (selector !== 3'b001 || sel_changed !== 1'b1) begin errors++; $display("FAIL midrst_latency got sel=%b chg=%b expected 001/1", selector, sel_changed); end
        btn_down = 1'b0;
        count_pulses(12, p);
        checks++; if (p !== 0 || selector !== 3'b001) begin errors++; $display("FAIL midrst_final got sel=%b pulses=%0d expected 001/0", selector, p); end
        $display("reset mid-press: selector=%b", selector);
    endtask

    initial begin
        #2;
        test_reset();
        test_single_press();
        test_bounce();
        test_simultaneous();
        test_saturation();
        test_reset_mid_press();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
